// File: rtl/cl_hello_world_reg_arb.sv
// Round-robin arbiter for two register requesters onto the
// hello-world core write/read port, one transaction in flight.
module cl_hello_world_reg_arb #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk_main_a0,
   input  logic              rst_main_n,
   input  logic              req0_valid,
   input  logic              req0_wr,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              req0_done,
   output logic [DATA_W-1:0] req0_rdata,
   input  logic              req1_valid,
   input  logic              req1_wr,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              req1_done,
   output logic [DATA_W-1:0] req1_rdata,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wdata,
   output logic              wready,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_en,
   input  logic [DATA_W-1:0] rd_data
);

   localparam int CW = $clog2(RD_LAT + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(RD_LAT - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RWAIT,
      DONE
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic              gnt0;
   logic              gnt1;
   logic              owner_q;
   logic              cmd_wr_q;
   logic              rr_ptr_q;
   logic [CW-1:0]     cnt_q;
   logic              win_wr;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata0_q;
   logic [DATA_W-1:0] rdata1_q;
   logic              done0_q;
   logic              done1_q;

   // Next-state, grant and core strobe decode; grants only while idle
   // and out of reset, rr_ptr_q set means req1 has priority.
   always_comb begin
      state_d = state_q;
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      wready  = 1'b0;
      rd_en   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rst_main_n) begin
               if (req0_valid && (!req1_valid || !rr_ptr_q))
                  gnt0 = 1'b1;
               else if (req1_valid)
                  gnt1 = 1'b1;
               if (gnt0 || gnt1)
                  state_d = ISSUE;
            end
         end
         ISSUE: begin
            wready  = cmd_wr_q;
            rd_en   = !cmd_wr_q;
            state_d = cmd_wr_q ? DONE : RWAIT;
         end
         RWAIT: begin
            if (cnt_q == '0)
               state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Winner command mux feeding the latch registers
   always_comb begin
      win_wr    = gnt1 ? req1_wr    : req0_wr;
      win_addr  = gnt1 ? req1_addr  : req0_addr;
      win_wdata = gnt1 ? req1_wdata : req0_wdata;
   end

   // State register
   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Latch owner, command and core address/data on every grant
   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) begin
         owner_q   <= 1'b0;
         cmd_wr_q  <= 1'b0;
         rr_ptr_q  <= 1'b0;
         wr_addr_q <= '0;
         wdata_q   <= '0;
         rd_addr_q <= '0;
      end else if (gnt0 || gnt1) begin
         owner_q  <= gnt1;
         cmd_wr_q <= win_wr;
         rr_ptr_q <= gnt0;
         if (win_wr) begin
            wr_addr_q <= win_addr;
            wdata_q   <= win_wdata;
         end else begin
            rd_addr_q <= win_addr;
         end
      end
   end

   // Read latency counter: loaded on rd_en, counts down to sample point
   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n)
         cnt_q <= '0;
      else if (state_q == ISSUE && !cmd_wr_q)
         cnt_q <= CNT_INIT;
      else if (state_q == RWAIT && cnt_q != '0)
         cnt_q <= cnt_q - CW'(1);
   end

   // Owner's rdata: core data on reads, zero on writes; other holds
   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) begin
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else if (state_q == RWAIT && cnt_q == '0) begin
         if (owner_q)
            rdata1_q <= rd_data;
         else
            rdata0_q <= rd_data;
      end else if (state_q == ISSUE && cmd_wr_q) begin
         if (owner_q)
            rdata1_q <= '0;
         else
            rdata0_q <= '0;
      end
   end

   // Registered one-cycle completion pulse for the owner only
   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) begin
         done0_q <= 1'b0;
         done1_q <= 1'b0;
      end else begin
         done0_q <= (state_d == DONE) && !owner_q;
         done1_q <= (state_d == DONE) && owner_q;
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign req0_done  = done0_q;
   assign req1_done  = done1_q;
   assign req0_rdata = rdata0_q;
   assign req1_rdata = rdata1_q;
   assign wr_addr    = wr_addr_q;
   assign wdata      = wdata_q;
   assign rd_addr    = rd_addr_q;

endmodule
